// File: rtl/parity_pkg.sv
// Shared types and constants for parity blocks.
package parity_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StDone
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_frame_checker_if.sv
// Word-stream input and frame-result output bundle for parity_frame_checker.
interface parity_frame_checker_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WORDS = 16
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              odd_mode;
  logic              chk_en;
  logic              chk_parity;
  logic              out_valid;
  logic              out_ready;
  logic              out_parity;
  logic              out_err;
  logic [CNT_W-1:0]  out_count;

  // Producer of words and consumer of results.
  modport master (
    output in_valid, in_data, in_last, odd_mode, chk_en, chk_parity, out_ready,
    input  in_ready, out_valid, out_parity, out_err, out_count
  );

  // The checker itself.
  modport slave (
    input  in_valid, in_data, in_last, odd_mode, chk_en, chk_parity, out_ready,
    output in_ready, out_valid, out_parity, out_err, out_count
  );
endinterface

// File: rtl/parity_reduce.sv
// Combinational XOR reduction of one word.
module parity_reduce #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  // Odd number of ones gives 1.
  always_comb begin
    parity_o = ^data_i;
  end

endmodule

// File: rtl/parity_frame_checker.sv
// Accumulates XOR parity over a frame of words and reports parity, check error
// and beat count once per frame.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_WORDS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  parity_frame_checker_if.slave    bus
);

  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  state_e           state_q, state_d;
  logic             acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             out_parity_q, out_parity_d;
  logic             out_err_q, out_err_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic             word_par;
  logic             beat;
  logic             first;
  logic             mode_nxt;
  logic             acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frame_end;
  logic             par_nxt;

  parity_reduce #(
    .DATA_W (DATA_W)
  ) u_reduce (
    .data_i   (bus.in_data),
    .parity_o (word_par)
  );

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_parity = out_parity_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_count  = out_count_q;

  // Next-state, accumulator update and result capture on the final beat.
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    count_d      = count_q;
    mode_d       = mode_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_parity_d = out_parity_q;
    out_err_d    = out_err_q;
    out_count_d  = out_count_q;

    beat  = bus.in_valid && in_ready_q;
    first = (state_q == StIdle);
    // The first beat of a frame starts from a clean accumulator and latches the mode.
    mode_nxt  = first ? bus.odd_mode : mode_q;
    acc_nxt   = (first ? 1'b0 : acc_q) ^ word_par;
    cnt_nxt   = (first ? '0 : count_q) + CNT_W'(1);
    frame_end = bus.in_last || (cnt_nxt == CNT_W'(MAX_WORDS));
    par_nxt   = acc_nxt ^ (mode_nxt == PAR_ODD);

    unique case (state_q)
      StIdle, StAccum: begin
        if (beat) begin
          mode_d  = mode_nxt;
          acc_d   = acc_nxt;
          count_d = cnt_nxt;
          if (frame_end) begin
            state_d      = StDone;
            in_ready_d   = 1'b0;
            out_valid_d  = 1'b1;
            out_parity_d = par_nxt;
            out_err_d    = bus.chk_en & (bus.chk_parity ^ par_nxt);
            out_count_d  = cnt_nxt;
          end else begin
            state_d = StAccum;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d     = StIdle;
          acc_d       = 1'b0;
          count_d     = '0;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= 1'b0;
      count_q      <= '0;
      mode_q       <= PAR_EVEN;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_parity_q <= 1'b0;
      out_err_q    <= 1'b0;
      out_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      count_q      <= count_d;
      mode_q       <= mode_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_parity_q <= out_parity_d;
      out_err_q    <= out_err_d;
      out_count_q  <= out_count_d;
    end
  end

endmodule

// File: tb/tb_parity_frame_checker.sv
// Self-checking bench for parity_frame_checker (MAX_WORDS=4 and MAX_WORDS=1 instances).
module tb_parity_frame_checker;

  localparam int unsigned MaxW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  parity_frame_checker_if #(.DATA_W(8), .MAX_WORDS(MaxW)) bus4 ();
  parity_frame_checker_if #(.DATA_W(8), .MAX_WORDS(1))    bus1 ();

  parity_frame_checker #(.DATA_W(8), .MAX_WORDS(MaxW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  parity_frame_checker #(.DATA_W(8), .MAX_WORDS(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  task automatic idle_inputs();
    bus4.in_valid = 0; bus4.in_data = 0; bus4.in_last = 0; bus4.odd_mode = 0;
    bus4.chk_en = 0; bus4.chk_parity = 0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.in_data = 0; bus1.in_last = 0; bus1.odd_mode = 0;
    bus1.chk_en = 0; bus1.chk_parity = 0; bus1.out_ready = 0;
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send_beat(input logic [7:0] d, input logic last, input logic mode,
                           input logic ce, input logic cp);
    int waited;
    waited = 0;
    bus4.in_valid = 1; bus4.in_data = d; bus4.in_last = last; bus4.odd_mode = mode;
    bus4.chk_en = ce; bus4.chk_parity = cp;
    while (bus4.in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_cmp++; n_fail++;
      $display("FAIL beat_accept_timeout: in_ready=%b required 1", bus4.in_ready);
    end
    @(negedge clk);
    bus4.in_valid = 0; bus4.in_last = 0;
  endtask

  // Called at the negedge right after the final beat; holds off out_ready for hold cycles.
  task automatic check_result(input string name, input logic ep, input logic ee,
                              input int ec, input int hold);
    n_cmp++;
    if (bus4.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s out_valid_latency: got %b required 1", name, bus4.out_valid);
    end
    n_cmp++;
    if (bus4.out_parity !== ep) begin
      n_fail++;
      $display("FAIL %s out_parity: got %b required %b", name, bus4.out_parity, ep);
    end
    n_cmp++;
    if (bus4.out_err !== ee) begin
      n_fail++;
      $display("FAIL %s out_err: got %b required %b", name, bus4.out_err, ee);
    end
    n_cmp++;
    if (bus4.out_count !== 3'(ec)) begin
      n_fail++;
      $display("FAIL %s out_count: got %0d required %0d", name, bus4.out_count, ec);
    end
    for (int i = 0; i < hold; i++) begin
      bus4.out_ready = 0;
      @(negedge clk);
      n_cmp++;
      if ({bus4.out_valid, bus4.in_ready, bus4.out_parity, bus4.out_err, bus4.out_count} !==
          {1'b1, 1'b0, ep, ee, 3'(ec)}) begin
        n_fail++;
        $display("FAIL %s hold_stable: got v=%b r=%b p=%b e=%b c=%0d required v=1 r=0 p=%b e=%b c=%0d",
                 name, bus4.out_valid, bus4.in_ready, bus4.out_parity, bus4.out_err,
                 bus4.out_count, ep, ee, ec);
      end
    end
    bus4.out_ready = 1;
    @(negedge clk);
    bus4.out_ready = 0;
    n_cmp++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b required 0 1",
               name, bus4.out_valid, bus4.in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus4.in_ready, bus4.out_valid, bus4.out_parity, bus4.out_err, bus4.out_count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got r=%b v=%b p=%b e=%b c=%0d required 1 0 0 0 0",
               bus4.in_ready, bus4.out_valid, bus4.out_parity, bus4.out_err, bus4.out_count);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_beat();
    send_beat(8'b0000_0111, 1, 0, 0, 0);
    check_result("single_even", 1'b1, 1'b0, 1, 0);
  endtask

  task automatic test_three_beat_odd();
    // 1+2+8 ones -> odd data parity, odd mode flips it to 0.
    send_beat(8'h01, 0, 1, 0, 0);
    send_beat(8'h03, 0, 0, 0, 0);
    send_beat(8'hFF, 1, 0, 1, 0);
    check_result("three_odd_ok", 1'b0, 1'b0, 3, 0);
    send_beat(8'h01, 0, 1, 0, 0);
    send_beat(8'h03, 0, 0, 0, 0);
    send_beat(8'hFF, 1, 0, 1, 1);
    check_result("three_odd_err", 1'b0, 1'b1, 3, 1);
  endtask

  task automatic test_forced_end();
    for (int i = 0; i < 4; i++) send_beat(8'h01, 0, 0, 0, 0);
    check_result("forced_end", 1'b0, 1'b0, 4, 0);
    send_beat(8'h01, 0, 1, 0, 0);
    // Frame 2: 1+2 ones -> 1, odd mode -> 0; chk_parity 1 mismatches.
    send_beat(8'h03, 1, 0, 1, 1);
    check_result("after_forced", 1'b0, 1'b1, 2, 0);
  endtask

  task automatic test_back_to_back_backpressure();
    send_beat(8'h55, 1, 0, 0, 0);
    // Pending beat held valid through DONE; must not be consumed until release.
    bus4.in_valid = 1; bus4.in_data = 8'h0F; bus4.in_last = 1; bus4.odd_mode = 1;
    bus4.chk_en = 0; bus4.chk_parity = 0;
    check_result("backpressure", 1'b0, 1'b0, 1, 5);
    @(negedge clk);
    bus4.in_valid = 0; bus4.in_last = 0;
    check_result("pending_beat", 1'b1, 1'b0, 1, 0);
  endtask

  task automatic test_mode_change();
    send_beat(8'h01, 0, 0, 0, 0);
    send_beat(8'h02, 0, 1, 0, 0);
    send_beat(8'h04, 1, 1, 0, 0);
    check_result("mode_change", 1'b1, 1'b0, 3, 0);
  endtask

  task automatic test_reset_mid_frame();
    send_beat(8'h01, 0, 1, 0, 0);
    send_beat(8'h03, 0, 1, 0, 0);
    #1 rst = 1;
    #1;
    n_cmp++;
    if ({bus4.in_ready, bus4.out_valid, bus4.out_parity, bus4.out_err, bus4.out_count} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got r=%b v=%b p=%b e=%b c=%0d required 1 0 0 0 0",
               bus4.in_ready, bus4.out_valid, bus4.out_parity, bus4.out_err, bus4.out_count);
    end
    #1 rst = 0;
    @(negedge clk);
    n_cmp++;
    if (bus4.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_output: got out_valid=%b required 0", bus4.out_valid);
    end
    send_beat(8'h80, 1, 0, 0, 0);
    check_result("after_reset", 1'b1, 1'b0, 1, 0);
  endtask

  // Random stream: frames split by in_last or by reaching MaxW beats.
  task automatic test_random();
    int       ones, cnt;
    logic     mode, last, m, ce, cp, ep, ee;
    logic [7:0] d;
    ones = 0; cnt = 0; mode = 0;
    for (int b = 0; b < 80; b++) begin
      d    = 8'($urandom);
      last = ($urandom_range(0, 3) == 0);
      m    = 1'($urandom);
      ce   = 1'($urandom);
      cp   = 1'($urandom);
      if (b == 79) last = 1;
      if ($urandom_range(0, 4) == 0) @(negedge clk);
      if (cnt == 0) mode = m;
      ones += $countones(d);
      cnt++;
      send_beat(d, last, m, ce, cp);
      if (last || cnt == MaxW) begin
        ep = 1'(ones % 2) ^ mode;
        ee = ce & (cp ^ ep);
        check_result("random", ep, ee, cnt, $urandom_range(0, 3));
        ones = 0; cnt = 0;
      end
    end
  endtask

  task automatic test_max_one();
    logic [7:0] d;
    logic       m, ep;
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      m = 1'($urandom);
      bus1.in_valid = 1; bus1.in_data = d; bus1.in_last = 1'($urandom); bus1.odd_mode = m;
      n_cmp++;
      if (bus1.in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL max1_ready: got %b required 1", bus1.in_ready);
      end
      @(negedge clk);
      bus1.in_valid = 0;
      ep = 1'($countones(d) % 2) ^ m;
      n_cmp++;
      if ({bus1.out_valid, bus1.out_parity, bus1.out_count} !== {1'b1, ep, 1'b1}) begin
        n_fail++;
        $display("FAIL max1_result: got v=%b p=%b c=%0d required v=1 p=%b c=1",
                 bus1.out_valid, bus1.out_parity, bus1.out_count, ep);
      end
      bus1.out_ready = 1;
      @(negedge clk);
      bus1.out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_three_beat_odd();
    test_forced_end();
    test_back_to_back_backpressure();
    test_mode_change();
    test_reset_mid_frame();
    test_random();
    test_max_one();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/parity_frame_checker.md
Name: parity_frame_checker

Overview:
Sequential, parametrised successor to the 3-input combinational parity function. It accepts a stream of DATA_W-bit words over a valid/ready handshake and accumulates the XOR parity across a frame. A frame ends on in_last or at MAX_WORDS beats. At frame end it presents an even/odd parity bit, an optional mismatch flag against a received parity bit, and the beat count. It sits between a serial/byte receiver and the frame-level error logic.

Parameters:
DATA_W, 8, width of each input word (1..64)
MAX_WORDS, 16, maximum beats per frame; forces frame end when reached (>=1)
CNT_W, $clog2(MAX_WORDS+1), width of beat counter (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input word valid
in_ready  output  1  block can accept a word this cycle
in_data  input  DATA_W  data word
in_last  input  1  final word of frame (qualified by in_valid)
odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on first beat of frame
chk_en  input  1  compare against chk_parity; sampled with final beat
chk_parity  input  1  received parity bit; sampled with final beat
out_valid  output  1  frame result valid
out_ready  input  1  consumer accepts result
out_parity  output  1  generated parity of frame
out_err  output  1  chk_en && (chk_parity != out_parity)
out_count  output  CNT_W  number of beats in frame (1..MAX_WORDS)

Behaviour:
- Reset (async, immediate): state=IDLE, acc=0, count=0, mode_q=0; in_ready=1, out_valid=0, out_parity=0, out_err=0, out_count=0.
- Beat accepted when in_valid && in_ready. Word parity = XOR reduction of in_data.
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1. On beat: latch odd_mode into mode_q, acc=^in_data, count=1. If frame end: go to DONE, else go to ACCUM.
  - ACCUM: in_ready=1. On beat: acc^=^in_data, count+=1. If frame end: go to DONE. No beat: hold.
  - DONE: in_ready=0, out_valid=1. On out_ready: go to IDLE, clear acc/count. Outputs hold stable while out_valid && !out_ready.
- Frame end = accepted beat with in_last=1, OR count reaching MAX_WORDS on this beat (in_last ignored). A forced end does not affect the next frame.
- Result registered on the final beat. out_valid asserts the cycle after the final beat (latency 1). Values:
  - out_parity = acc_final ^ mode_q.
  - out_err = chk_en_q & (chk_parity_q ^ out_parity).
  - out_count = final count.
- Throughput: at most one frame per (beats+1) cycles. No beat is accepted in the cycle out_ready is taken; in_ready returns to 1 the following cycle.
- odd_mode changes mid-frame are ignored. chk_en/chk_parity are only meaningful on the final beat.
- MAX_WORDS=1: every beat is a frame.
- out_valid with out_ready held high: result visible for exactly one cycle.
- Reset asserted mid-frame or in DONE: partial frame discarded, no output produced. First beat after reset release starts a new frame.
- out_parity/out_err/out_count are don't-care-stable (held last value) when out_valid=0. The bench checks them only with out_valid.

Decomposition:
- Shared package parity_pkg: state enum (IDLE, ACCUM, DONE), parity mode constants PAR_EVEN=0 and PAR_ODD=1.
- One sub-module is natural: parity_reduce (combinational, parameter DATA_W, output ^in_data). It is reused by other parity blocks.
- FSM, accumulator and output register stay in parity_frame_checker.

Test Plan:
- Single-beat even frame: DATA_W=8, in_data=8'b0000_0111, in_last=1, odd_mode=0, chk_en=0 -> next cycle out_valid=1, out_parity=1, out_err=0, out_count=1.
- 3-beat odd frame: 8'h01, 8'h03, 8'hFF (last), odd_mode=1 on first beat, chk_en=1, chk_parity=0 -> acc=1, out_parity=0, out_err=0, out_count=3. Repeat with chk_parity=1 -> out_err=1.
- Forced end: MAX_WORDS=4, five beats of 8'h01 with in_last=0 -> frame 1: out_count=4, out_parity=0. After out_ready, 5th beat starts frame 2 (count=1 so far).
- Backpressure: hold out_ready=0 for 5 cycles in DONE while in_valid=1 -> in_ready=0, outputs stable, no beat consumed. Raise out_ready -> out_valid drops next cycle, pending beat accepted.
- Mid-frame mode change: odd_mode=0 on beat 1, toggled to 1 on beats 2-3 -> parity computed as even.
- Reset mid-frame: 2 beats accepted, rst pulsed between clock edges -> outputs immediately at reset values, no out_valid. A following 1-beat frame 8'h80 gives out_parity=1 (even), out_count=1.
